// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux; {s0,s1} = owner index, one-hot gnt back to requesters.
// Latency: request seen at edge N -> registered grant after edge N+1; one IDLE turnaround cycle after every tenure.
// Backpressure: a tenure ends on owner release or after MAX_HOLD cycles when others wait; `define ARB_LOCK_EN adds `lock` to suppress the hold limit.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
        $error("mux4_rr_arbiter: MAX_HOLD out of range or CNT_W too narrow");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    logic             win_vld;
    logic [1:0]       win_idx;
    logic [3:0]       own_oh;
    logic             others_pend;
    logic             lock_hold;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Scan from the farthest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                win_vld = 1'b1;
                win_idx = ptr_q + 2'(k);
            end
        end
    end

    assign own_oh      = 4'b0001 << sel_q;
    assign others_pend = |(req & ~own_oh);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (win_vld) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Owner release takes precedence, so a coinciding limit never pulses preempt.
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                end else if (cnt_q == HOLD_LAST && others_pend && !lock_hold) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    ptr_d     = sel_q + 2'd1;
                    preempt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign s0      = sel_q[1];
    assign s1      = sel_q[0];
    assign busy    = (state_q == GRANT);
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD=8); observed vector is {gnt, s0, s1, busy, preempt}.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;
    logic       preempt;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif

    logic [7:0] obs;
    int         n_chk;
    int         n_pass;
    int         n_fail;

    mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .s0      (s0),
        .s1      (s1),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {gnt, s0, s1, busy, preempt};

    task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] sel,
                       input logic b, input logic p);
        logic [7:0] exp;
        exp = {g, sel, b, p};
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed gnt/sel/busy/preempt=%b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] o;
        logic [3:0] oh;
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        reset  = 1'b1;
        req    = 4'b0000;
`ifdef ARB_LOCK_EN
        lock   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_state", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Basic grant, release, rotation to the next requester.
        reset = 1'b0;
        req   = 4'b1010;
        @(negedge clk); chk("first_gnt", 4'b0010, 2'b01, 1'b1, 1'b0);
        req = 4'b1000;
        @(negedge clk); chk("release_idle", 4'b0000, 2'b01, 1'b0, 1'b0);
        @(negedge clk); chk("next_gnt3", 4'b1000, 2'b11, 1'b1, 1'b0);
        req = 4'b0000;
        @(negedge clk); chk("idle_sel_hold", 4'b0000, 2'b11, 1'b0, 1'b0);

        // Fairness: all request, each owner drops for one cycle after two grant cycles.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            o  = 2'(i % 4);
            oh = 4'b0001 << o;
            @(negedge clk); chk("rot_gnt_c1", oh, o, 1'b1, 1'b0);
            @(negedge clk); chk("rot_gnt_c2", oh, o, 1'b1, 1'b0);
            req[o] = 1'b0;
            @(negedge clk); chk("rot_idle", 4'b0000, o, 1'b0, 1'b0);
            req[o] = 1'b1;
        end
        req = 4'b0000;
        @(negedge clk); chk("rot_quiet", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Lone owner keeps the grant past the limit; a competitor triggers preemption.
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); chk("lone_hold", 4'b0100, 2'b10, 1'b1, 1'b0);
        end
        req = 4'b0101;
        @(negedge clk); chk("preempt_pulse", 4'b0000, 2'b10, 1'b0, 1'b1);
        @(negedge clk); chk("preempt_handover", 4'b0001, 2'b00, 1'b1, 1'b0);

        // Competitor pending from the start: exactly 8 grant cycles, then preemption.
        req = 4'b0011;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk); chk("limit_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        @(negedge clk); chk("limit_preempt", 4'b0000, 2'b00, 1'b0, 1'b1);
        @(negedge clk); chk("limit_next", 4'b0010, 2'b01, 1'b1, 1'b0);
        req = 4'b0000;
        @(negedge clk); chk("limit_release", 4'b0000, 2'b01, 1'b0, 1'b0);

        // Asynchronous reset between clock edges mid-tenure.
        req = 4'b1000;
        @(negedge clk); chk("pre_reset_gnt", 4'b1000, 2'b11, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk("async_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        @(negedge clk); chk("reset_held", 4'b0000, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;

        // Release coinciding with the hold limit is a plain release.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); chk("post_reset_hold", 4'b1000, 2'b11, 1'b1, 1'b0);
        end
        req = 4'b0001;
        @(negedge clk); chk("coincide_release", 4'b0000, 2'b11, 1'b0, 1'b0);
        @(negedge clk); chk("coincide_next", 4'b0001, 2'b00, 1'b1, 1'b0);

`ifdef ARB_LOCK_EN
        lock = 1'b1;
        req  = 4'b0011;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); chk("lock_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        lock = 1'b0;
        @(negedge clk); chk("unlock_preempt", 4'b0000, 2'b00, 1'b0, 1'b1);
        @(negedge clk); chk("unlock_next", 4'b0010, 2'b01, 1'b1, 1'b0);
`endif

        req = 4'b0000;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 multiplexer between four requesters.
- Drives the mux select pair `s0`/`s1` with one-hot grant back to the requesters.
- Bounds each tenure with a hold limit so no requester starves the others.
- Sits in front of the conditional-operator 4:1 mux; select encoding matches it: `{s0,s1}` = selected input index, with `s0` as the MSB.

Parameters:
- MAX_HOLD, 8: maximum consecutive GRANT cycles for one owner while another request is pending (legal range 2..255).
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; bit i = mux input in<i>.
- gnt  output  4  one-hot grant, registered; all-zero when no owner.
- s0  output  1  mux select MSB (registered).
- s1  output  1  mux select LSB (registered).
- busy  output  1  high while in GRANT.
- preempt  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD.

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-tenure):
  - gnt=0, s0=0, s1=0, busy=0, preempt=0, hold_cnt=0, state=IDLE.
  - Priority pointer ptr=0, so search order is 0,1,2,3.
- State IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, ... mod 4.
  - Next edge: gnt=onehot(winner), {s0,s1}=winner, busy=1, hold_cnt=0, go GRANT.
  - If req == 0, stay in IDLE; outputs hold their last select value, gnt=0.
- Grant latency: request seen at edge N gives grant valid after edge N+1 (1 cycle).
- State GRANT (owner o):
  - Each cycle hold_cnt increments and saturates at MAX_HOLD-1.
  - Release when req[o]==0. Next edge: gnt=0, busy=0, ptr=(o+1) mod 4, go IDLE.
  - Preempt when hold_cnt==MAX_HOLD-1 and (req & ~onehot(o)) != 0. Next edge: same as release, plus preempt=1 for exactly that one cycle.
  - If hold_cnt==MAX_HOLD-1 and no other request is pending, the owner keeps the grant indefinitely (counter saturated); preemption fires as soon as another request appears.
  - Release and preempt coinciding: treated as a release; preempt stays 0.
- Every tenure end is followed by exactly one IDLE turnaround cycle with gnt=0 before the next grant.
- s0/s1 hold the last owner's index during IDLE; they change only on a new grant.
- Requests arriving or dropping for non-owners during GRANT have no effect until IDLE.
- gnt is never multi-hot. gnt is nonzero only in GRANT.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input port `lock` (1 bit).
  - While in GRANT with lock==1 and req[o]==1, preemption is suppressed; hold_cnt still saturates.
  - When lock drops with other requests pending and hold_cnt saturated, preempt fires on the next edge.
  - Release by req[o]==0 is unaffected by lock.
- When undefined: no `lock` port; behaviour exactly as above.

Test Plan:
- Reset then req=4'b1010 held -> after 1 cycle gnt=4'b0010, {s0,s1}=01, busy=1.
  - Drop req[1] -> next cycle gnt=0 (IDLE).
  - Following cycle gnt=4'b1000, {s0,s1}=11.
- Rotation fairness: req=4'b1111, each owner drops req for one cycle after 2 GRANT cycles, then re-raises it -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Preemption (MAX_HOLD=8):
  - req[2] held alone for 20 cycles -> gnt=4'b0100 kept, preempt=0.
  - Raise req[0] -> next edge gnt=0 and preempt=1 for 1 cycle.
  - Then gnt=4'b0001, {s0,s1}=00, ptr moved past 2.
- Asynchronous reset asserted mid-GRANT, between clock edges -> gnt, s0, s1, busy immediately 0.
  - After reset deasserts with req=4'b1000 -> gnt=4'b1000 one cycle later (ptr back to 0).
- Simultaneous release and limit: owner drops req exactly when hold_cnt==MAX_HOLD-1 with another req pending -> IDLE, preempt stays 0.
- ARB_LOCK_EN defined: lock=1 with competing req -> no preemption after 30 cycles.
  - Deassert lock -> preempt pulse on the next edge and handover.
